// File: rtl/translation_pkg.sv
// Shared types and constants for the switch-to-display translation path:
// FSM state encoding, seven-segment glyph ROM, conversion step count and
// the BCD add-3 adjust used by the double-dabble engine.
package translation_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Number of shift-add-3 iterations for an 8-bit binary input.
  localparam int CONV_STEPS = 8;

  // Active-high glyphs (gfedcba) for hex digits 0..F.
  localparam logic [6:0] SEG_ROM [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Active-high "all segments off"; the decoder applies output polarity.
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/translation_ctrl_if.sv
// Request/display bundle between the board-side driver (master) and the
// translation controller (slave).
interface translation_ctrl_if;
  logic       set;
  logic [7:0] sw;
  logic       busy;
  logic       done;
  logic [7:0] ledr;
  logic       ledg8;
  logic [6:0] hex4;
  logic [6:0] hex5;
  logic [6:0] dec6;
  logic [6:0] dec7;

  modport master (
    output set, sw,
    input  busy, done, ledr, ledg8, hex4, hex5, dec6, dec7
  );

  modport slave (
    input  set, sw,
    output busy, done, ledr, ledg8, hex4, hex5, dec6, dec7
  );
endinterface

// File: rtl/translation_ctrl_seg7_decode.sv
// Nibble to seven-segment (gfedcba) decoder with a blank override and
// selectable output polarity. Purely combinational; the caller registers.
module seg7_decode
  import translation_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  logic [6:0] raw;

  // Look up the glyph, force blank if requested, then apply polarity.
  always_comb begin
    raw   = blank_i ? SEG_BLANK : SEG_ROM[nib_i];
    seg_o = SEG_ACTIVE_LOW ? ~raw : raw;
  end

endmodule

// File: rtl/translation_ctrl.sv
// Sequencing controller: on a rising edge of set it captures sw, runs an
// 8-step double-dabble conversion, then commits hex, decimal and overflow
// results to registered display outputs with a busy/done handshake.
// Optional feature macro: TRANSLATION_PENDING_EN (one-deep request queue
// for requests arriving while a conversion is in flight).
module translation_ctrl
  import translation_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  translation_ctrl_if.slave  bus
);

  localparam logic [6:0] BLANK_OUT = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [3:0] LAST_STEP = 4'(CONV_STEPS - 1);

  state_t      state_q;
  logic        set_q;
  logic [7:0]  val_q;
  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [7:0]  ledr_q;
  logic        ledg8_q;
  logic [6:0]  hex4_q, hex5_q, dec6_q, dec7_q;

  logic        start;
  logic [19:0] shift_d;

`ifdef TRANSLATION_PENDING_EN
  logic        pend_q;
  logic [7:0]  pend_val_q;
  logic [7:0]  next_val_d;
`endif

  // Decoder wiring: 0=hex4 (low nibble), 1=hex5, 2=dec6 (ones), 3=dec7 (tens).
  logic [3:0] nib   [4];
  logic       blank [4];
  logic [6:0] seg   [4];

  // Rising-edge request and one double-dabble iteration (adjust, then shift).
  always_comb begin
    start   = bus.set & ~set_q;
    shift_d = {bcd_adjust(bcd_q), bin_q} << 1;
  end

  // Decoder inputs; only the tens digit may be blanked when it is zero.
  always_comb begin
    nib[0]   = val_q[3:0];
    nib[1]   = val_q[7:4];
    nib[2]   = bcd_q[3:0];
    nib[3]   = bcd_q[7:4];
    blank[0] = 1'b0;
    blank[1] = 1'b0;
    blank[2] = 1'b0;
    blank[3] = BLANK_LEADING && (bcd_q[7:4] == 4'd0);
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dec
      seg7_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
        .nib_i   (nib[gi]),
        .blank_i (blank[gi]),
        .seg_o   (seg[gi])
      );
    end
  endgenerate

`ifdef TRANSLATION_PENDING_EN
  // A request arriving in the COMMIT cycle itself is newer than any pending one.
  always_comb next_val_d = start ? bus.sw : pend_val_q;
`endif

  // Controller FSM with registered handshake and display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      set_q   <= 1'b0;
      val_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ledr_q  <= '0;
      ledg8_q <= 1'b0;
      hex4_q  <= BLANK_OUT;
      hex5_q  <= BLANK_OUT;
      dec6_q  <= BLANK_OUT;
      dec7_q  <= BLANK_OUT;
`ifdef TRANSLATION_PENDING_EN
      pend_q     <= 1'b0;
      pend_val_q <= '0;
`endif
    end else begin
      set_q  <= bus.set;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            val_q   <= bus.sw;
            bin_q   <= bus.sw;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          {bcd_q, bin_q} <= shift_d;
          cnt_q          <= cnt_q + 4'd1;
          if (cnt_q == LAST_STEP) state_q <= COMMIT;
`ifdef TRANSLATION_PENDING_EN
          if (start) begin
            pend_q     <= 1'b1;
            pend_val_q <= bus.sw;
          end
`endif
        end
        COMMIT: begin
          ledr_q  <= val_q;
          ledg8_q <= (bcd_q[11:8] != 4'd0);
          hex4_q  <= seg[0];
          hex5_q  <= seg[1];
          dec6_q  <= seg[2];
          dec7_q  <= seg[3];
          done_q  <= 1'b1;
`ifdef TRANSLATION_PENDING_EN
          pend_q <= 1'b0;
          if (pend_q || start) begin
            val_q   <= next_val_d;
            bin_q   <= next_val_d;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= CONV;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
`else
          busy_q  <= 1'b0;
          state_q <= IDLE;
`endif
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.ledr  = ledr_q;
  assign bus.ledg8 = ledg8_q;
  assign bus.hex4  = hex4_q;
  assign bus.hex5  = hex5_q;
  assign bus.dec6  = dec6_q;
  assign bus.dec7  = dec7_q;

endmodule

// File: tb/tb_translation_ctrl.sv
// Directed bench for translation_ctrl (active-low segments, leading blank).
// Expected segment codes are hand-derived from the glyph table, inverted.
module tb_translation_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc;
  int   bcnt;
  int   dcnt;

  always #5 clk = ~clk;

  translation_ctrl_if bus ();

  translation_ctrl #(
    .SEG_ACTIVE_LOW (1'b1),
    .BLANK_LEADING  (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outs(input string tag, input logic [7:0] ledr, input logic ledg8,
                            input logic [6:0] h5, input logic [6:0] h4,
                            input logic [6:0] d7, input logic [6:0] d6);
    $display("txn %s: ledr=%02h ledg8=%0d hex5=%02h hex4=%02h dec7=%02h dec6=%02h",
             tag, bus.ledr, bus.ledg8, bus.hex5, bus.hex4, bus.dec7, bus.dec6);
    check({tag, ".ledr"},  32'(bus.ledr),  32'(ledr));
    check({tag, ".ledg8"}, 32'(bus.ledg8), 32'(ledg8));
    check({tag, ".hex5"},  32'(bus.hex5),  32'(h5));
    check({tag, ".hex4"},  32'(bus.hex4),  32'(h4));
    check({tag, ".dec7"},  32'(bus.dec7),  32'(d7));
    check({tag, ".dec6"},  32'(bus.dec6),  32'(d6));
  endtask

  // One-cycle set pulse; returns at the negedge after the capturing edge.
  task automatic request(input logic [7:0] v);
    @(negedge clk);
    bus.sw  = v;
    bus.set = 1'b1;
    @(negedge clk);
    bus.set = 1'b0;
  endtask

  // Bounded wait for done; counts negedges waited and busy-high samples.
  task automatic wait_done(output int c, output int b);
    c = 0;
    b = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
      if (bus.busy === 1'b1) b++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    bus.set = 1'b0;
    bus.sw  = 8'd0;
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check_outs("rst", 8'h00, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    rst = 1'b0;

    // Reset in the middle of a conversion discards it.
    request(8'd200);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst.busy", 32'(bus.busy), 32'd0);
    check_outs("midrst", 8'h00, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    repeat (3) @(negedge clk);
    rst  = 1'b0;
    dcnt = 0;
    repeat (14) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcnt++;
    end
    check("midrst.no_done", 32'(dcnt), 32'd0);

    // Value 5: nine busy cycles, then a single done pulse.
    request(8'd5);
    wait_done(cyc, bcnt);
    check("v5.latency", 32'(cyc), 32'd9);
    check("v5.busy_cycles", 32'(bcnt), 32'd9);
    check("v5.busy_at_done", 32'(bus.busy), 32'd0);
    check_outs("v5", 8'h05, 1'b0, 7'h40, 7'h12, 7'h7F, 7'h12);
    @(negedge clk);
    check("v5.done_one_cycle", 32'(bus.done), 32'd0);

    // Value 154: overflow, low two decimal digits shown.
    request(8'd154);
    wait_done(cyc, bcnt);
    check("v154.latency", 32'(cyc), 32'd9);
    check_outs("v154", 8'h9A, 1'b1, 7'h10, 7'h08, 7'h12, 7'h19);

    // Value 254 with a second request 3 cycles later (sw=0) during CONV.
    request(8'd254);
    repeat (2) @(negedge clk);
    bus.sw  = 8'd0;
    bus.set = 1'b1;
    @(negedge clk);
    bus.set = 1'b0;
    wait_done(cyc, bcnt);
    check("v254.latency", 32'(cyc), 32'd6);
    check_outs("v254", 8'hFE, 1'b1, 7'h0E, 7'h06, 7'h12, 7'h19);
    @(negedge clk);
`ifdef TRANSLATION_PENDING_EN
    check("pend.busy_held", 32'(bus.busy), 32'd1);
    wait_done(cyc, bcnt);
    check("pend.latency", 32'(cyc), 32'd8);
    check_outs("pend0", 8'h00, 1'b0, 7'h40, 7'h40, 7'h7F, 7'h40);
`else
    check("drop.busy", 32'(bus.busy), 32'd0);
    dcnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcnt++;
    end
    check("drop.no_done", 32'(dcnt), 32'd0);
    check("drop.ledr_kept", 32'(bus.ledr), 32'hFE);
`endif

    // set held high for 30 cycles: exactly one conversion.
    @(negedge clk);
    bus.sw  = 8'd99;
    bus.set = 1'b1;
    dcnt    = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcnt++;
    end
    bus.set = 1'b0;
    check("held.done_count", 32'(dcnt), 32'd1);
    check_outs("v99", 8'h63, 1'b0, 7'h02, 7'h30, 7'h10, 7'h10);

    // set already high when reset releases counts as an edge.
    @(negedge clk);
    rst     = 1'b1;
    bus.set = 1'b1;
    bus.sw  = 8'd42;
    @(negedge clk);
    rst = 1'b0;
    wait_done(cyc, bcnt);
    bus.set = 1'b0;
    check("rstedge.latency", 32'(cyc), 32'd10);
    check_outs("v42", 8'h2A, 1'b0, 7'h24, 7'h08, 7'h19, 7'h24);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/translation_ctrl.md
Name: translation_ctrl

Overview:
- Sequencing controller for the switch-to-display translation path.
- On a `set` request it captures the 8-bit switch value and converts it to BCD with a multi-cycle shift-add-3 (double-dabble) engine.
- Commits hex, decimal and overflow results to registered display outputs and signals completion with a busy/done handshake.
- Sits between debounced board keys/switches and the seven-segment/LED drivers.

Parameters:
- SEG_ACTIVE_LOW, 1, 1: segment outputs are active-low (lit = 0). 0: active-high.
- BLANK_LEADING, 1, 1: blank `dec7` when the tens digit is 0.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- set  input  1  conversion request; level, rising-edge detected internally
- sw  input  8  binary value to translate
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse when results are committed
- ledr  output  8  committed binary value
- ledg8  output  1  decimal overflow (value > 99)
- hex4  output  7  low hex nibble, segments gfedcba
- hex5  output  7  high hex nibble
- dec6  output  7  decimal ones digit
- dec7  output  7  decimal tens digit

Behaviour:
- Reset (asynchronous, active-high):
  - FSM returns to IDLE; `set_q`=0.
  - busy=0, done=0, ledr=0, ledg8=0.
  - hex4/hex5/dec6/dec7 = BLANK (7'h7F when active-low).
  - Any in-flight or pending request is discarded.
- Request detection:
  - `start = set & ~set_q`.
  - `set` held high produces exactly one request.
  - `set` already high when reset is released counts as an edge on the first clock.
- FSM states: IDLE, CONV, COMMIT.
- IDLE, on start at edge k:
  - bin ← sw, bcd ← 12'h000, cnt ← 0.
  - Go to CONV; busy=1 from edge k.
- CONV, one iteration per cycle:
  - Each BCD nibble ≥ 5 gets +3.
  - Then `{bcd, bin}` shifts left by 1.
  - cnt increments; after the 8th iteration (edge k+8) go to COMMIT.
- COMMIT, at edge k+9:
  - ledr ← captured value; hex5/hex4 ← decode of high/low nibble.
  - dec6 ← ones digit; dec7 ← tens digit (BLANK if tens=0 and BLANK_LEADING).
  - ledg8 ← (hundreds ≠ 0).
  - done=1 for one cycle, busy=0, go to IDLE.
  - Outputs are valid from edge k+9 and hold until the next commit.
- Request while busy (CONV/COMMIT): ignored unless the optional feature is enabled. `sw` changes during CONV have no effect.
- Hundreds digit is never displayed. Values 100–255 show the low two decimal digits with ledg8=1.
- Segment encoding (active-high, gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Active-low outputs are the bitwise inverse.

Optional Feature:
- Macro: TRANSLATION_PENDING_EN.
- Defined:
  - A start during CONV/COMMIT sets a one-deep pending flag and captures `sw` into a pending register.
  - A later start overwrites the pending register.
  - In COMMIT with pending set: go directly to CONV with the pending value; clear pending; busy stays 1; done still pulses.
- Undefined: requests while busy are dropped; no pending storage is synthesised.

Decomposition:
- Package `translation_pkg`: FSM state enum, 16-entry segment ROM constants, SEG_BLANK, CONV_STEPS=8.
- Sub-module `seg7_decode`: 4-bit nibble plus blank input → 7-bit segments, with SEG_ACTIVE_LOW parameter. Four instances.

Test Plan:
- Reset asserted mid-CONV (after sw=8'd200 request) → all outputs at reset values immediately, no done pulse; next request converts normally.
- set rising with sw=8'd5 (active-low) → busy for 9 cycles, then done pulse.
  - hex5=7'h40, hex4=7'h12, dec7=7'h7F, dec6=7'h12.
  - ledr=8'h05, ledg8=0.
- sw=8'd154 request → ledr=8'h9A, hex5=7'h10, hex4=7'h08, dec7=7'h12, dec6=7'h19, ledg8=1.
- sw=8'd254 request → hex5=7'h0E, hex4=7'h06, dec7=7'h12, dec6=7'h19, ledg8=1.
  - Second edge 3 cycles later with sw=8'd0: ignored without TRANSLATION_PENDING_EN.
  - With the macro: busy held, then commit with dec6=7'h40, dec7=7'h7F, ledg8=0.
- set held high 30 cycles with sw=8'd99 → exactly one done pulse; dec7=dec6=7'h10, ledg8=0.
